// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, FIFO depth and header field positions.
package router_pkg;
   localparam int DATA_W     = 8;
   localparam int FIFO_DEPTH = 16;
   localparam int LEN_MSB    = 7;
   localparam int LEN_LSB    = 2;
   localparam int ADDR_MSB   = 1;
   localparam int ADDR_LSB   = 0;
   localparam int LEN_W      = LEN_MSB - LEN_LSB + 1;
   localparam int CNT_W      = LEN_W + 1;

   // Bytes still to come after a header: payload length plus the parity byte.
   function automatic logic [CNT_W-1:0] hdr_count(input logic [LEN_W-1:0] len);
      return CNT_W'(len) + CNT_W'(1);
   endfunction
endpackage

// File: rtl/router_fifo_if.sv
// Decoder/consumer-facing signal bundle of one per-destination router FIFO.
interface router_fifo_if
   import router_pkg::*;
#(
   parameter int WIDTH = DATA_W
);
   logic             soft_reset;
   logic             write_enb;
   logic             read_enb;
   logic             lfd_state;
   logic [WIDTH-1:0] data_in;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             empty;
   logic             pkt_active;

   modport master (
      output soft_reset, write_enb, read_enb, lfd_state, data_in,
      input  data_out, full, empty, pkt_active
   );
   modport slave (
      input  soft_reset, write_enb, read_enb, lfd_state, data_in,
      output data_out, full, empty, pkt_active
   );
endinterface

// File: rtl/router_fifo.sv
// Per-destination packet FIFO: stores bytes with a header flag and tracks the
// remaining byte count of the packet being drained on the read side.
module router_fifo
   import router_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic         clk,
   input  logic         resetn,
   router_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]      PTR_ONE = (AW+1)'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [WIDTH:0]   r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [CNT_W-1:0] r_pkt_cnt;
   logic [WIDTH-1:0] r_data_out;

   logic             w_empty;
   logic             w_full;
   logic             w_wr;
   logic             w_rd;
   logic [WIDTH:0]   w_rd_entry;

   // Extra pointer MSB tells a wrapped-full FIFO apart from an empty one.
   assign w_empty    = (r_wr_ptr == r_rd_ptr);
   assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_wr       = bus.write_enb && !w_full  && !bus.soft_reset;
   assign w_rd       = bus.read_enb  && !w_empty && !bus.soft_reset;
   assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pkt_cnt  <= '0;
         r_data_out <= '0;
      end else if (bus.soft_reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_pkt_cnt  <= '0;
         r_data_out <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_rd) begin
            r_rd_ptr   <= r_rd_ptr + PTR_ONE;
            r_data_out <= w_rd_entry[WIDTH-1:0];
            // A stray payload byte with no open packet leaves the counter at zero.
            if (w_rd_entry[WIDTH])
               r_pkt_cnt <= hdr_count(w_rd_entry[LEN_MSB:LEN_LSB]);
            else if (r_pkt_cnt != '0)
               r_pkt_cnt <= r_pkt_cnt - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr)
         r_mem[r_wr_ptr[AW-1:0]] <= {bus.lfd_state, bus.data_in};
   end

   assign bus.data_out   = r_data_out;
   assign bus.full       = w_full;
   assign bus.empty      = w_empty;
   assign bus.pkt_active = (r_pkt_cnt != '0);
endmodule
